lsu_unit: RTL and testbench

Load/store unit sitting directly downstream of the execute-stage ALU in the miniproj4 RISC-V datapath. It takes the ALU result as the effective address, plus rs2 store data and funct3, and performs one memory transaction over a req/ready bus. Byte and halfword stores are converted into lane-replicated data with a write mask; loads are extracted and sign- or zero-extended. It reports completion, misalignment, illegal funct3 and bus timeout back to the core controller.

---
 rtl/lsu_unit.sv | 171 +++++++++++++++++
 tb/tb_lsu_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit behind the execute-stage ALU.
// One memory transaction per start request over a req/ready bus.
// Stores become lane-replicated data with a byte mask. Loads are
// extracted from the addressed lane and then sign- or zero-extended.
// Completion, misalignment, illegal funct3 and bus timeout are reported
// with a one-cycle done pulse.
//
// Bus handshake: mem_req is high in every ACCESS cycle. mem_we, mem_addr,
// mem_wdata and mem_wmask are registered on ACCESS entry and stay stable
// until mem_ready is seen. The transfer completes in the first cycle where
// mem_req and mem_ready are both high; mem_rdata is sampled in that cycle.
// mem_ready is ignored in every other cycle.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Last ACCESS count value before an abort (counter starts at 0).
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [2:0]  op_f3;
  logic [1:0]  off;
  logic [7:0]  tcnt;

  logic        f3_legal;
  logic        misal;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] lane;
  logic [31:0] ld_value;

  // Status outputs decode straight from state so they follow reset at once.
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign mem_req = (state == S_ACCESS);

  // Decode the incoming request: legality, alignment and store lanes.
  always_comb begin
    f3_legal = 1'b0;
    misal    = 1'b0;
    st_wdata = 32'd0;
    st_wmask = 4'd0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !is_store;
      default:                f3_legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   misal = addr[0];
      2'b10:   misal = |addr[1:0];
      default: misal = 1'b0;
    endcase
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          st_wdata = {4{wdata[7:0]}};
          st_wmask = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          st_wdata = {2{wdata[15:0]}};
          st_wmask = 4'b0011 << addr[1:0];
        end
        default: begin
          st_wdata = wdata;
          st_wmask = 4'b1111;
        end
      endcase
    end
  end

  // Shift the addressed lane down and extend it according to the latched funct3.
  always_comb begin
    lane     = mem_rdata >> {off, 3'b000};
    ld_value = lane;
    case (op_f3)
      3'b000:  ld_value = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_value = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_value = {24'd0, lane[7:0]};
      3'b101:  ld_value = {16'd0, lane[15:0]};
      default: ld_value = lane;
    endcase
  end

  // Control FSM plus the registered bus fields, result and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_f3     <= 3'd0;
      off       <= 2'd0;
      tcnt      <= 8'd0;
      err       <= ERR_OK;
      rdata     <= 32'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_f3 <= funct3;
            off   <= addr[1:0];
            tcnt  <= 8'd0;
            if (!f3_legal) begin
              err   <= ERR_ILLEGAL;
              state <= S_DONE;
            end else if (misal) begin
              err   <= ERR_MISALGN;
              state <= S_DONE;
            end else begin
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wmask <= st_wmask;
              state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            err   <= ERR_OK;
            state <= S_DONE;
            if (!mem_we) begin
              rdata <= ld_value;
            end
          end else if (tcnt == TLIM) begin
            err   <= ERR_TIMEOUT;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: randomized and directed checks of lsu_unit against a
// behavioural model of the load/store rules.
module tb_lsu_unit;

  localparam int T = 4;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  logic [33:0] exp_q[$];
  logic [31:0] model_rdata = 32'd0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [3:0]  exp_wmask = 4'd0;

  always #5 clk = ~clk;

  lsu_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [1:0] model_err(input logic st, input logic [2:0] f3, input logic [1:0] a);
    bit legal;
    int size;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2'b10;
    size = 1 << f3[1:0];
    if ((int'(a) % size) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a);
    case (f3)
      3'd0:    return 32'($signed(s[7:0]));
      3'd1:    return 32'($signed(s[15:0]));
      3'd4:    return 32'(s[7:0]);
      3'd5:    return 32'(s[15:0]);
      default: return s;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] wd,
                             output logic [31:0] d, output logic [3:0] m);
    case (f3)
      3'd0: begin d = {4{wd[7:0]}};  m = 4'(1 << a); end
      3'd1: begin d = {2{wd[15:0]}}; m = 4'(3 << a); end
      default: begin d = wd; m = 4'hF; end
    endcase
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n) begin
      if (mem_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          chk("err", {30'd0, err}, {30'd0, e[33:32]});
          chk("rdata", rdata, e[31:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int wait_n, input logic [31:0] rd,
                         input bit poke);
    logic [1:0] e;
    int exp_done;
    int exp_req;
    int reqs;
    int c;
    bit seen;
    bit fault;
    @(negedge clk);
    e = model_err(st, f3, a[1:0]);
    fault = (e != 2'b00);
    exp_addr = {a[31:2], 2'b00};
    exp_we = st;
    if (st) model_store(f3, a[1:0], wd, exp_wdata, exp_wmask);
    else begin exp_wdata = 32'd0; exp_wmask = 4'd0; end
    if (fault) begin
      exp_done = 1; exp_req = 0;
    end else if (wait_n < T) begin
      exp_done = 2 + wait_n; exp_req = wait_n + 1;
      if (!st) model_rdata = model_load(f3, a[1:0], rd);
    end else begin
      exp_done = T + 1; exp_req = T; e = 2'b11;
    end
    exp_q.push_back({e, model_rdata});
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = $urandom; wdata = $urandom;
    reqs = 0; seen = 1'b0; c = 0;
    for (int k = 1; k <= 300 && !seen; k++) begin
      @(negedge clk);
      if (fault) mem_ready = 1'($urandom);
      else       mem_ready = (k == 1 + wait_n);
      mem_rdata = mem_ready ? rd : $urandom;
      if (mem_req) reqs++;
      if (done) begin
        seen = 1'b1;
        c = k;
        if (poke) begin
          start = 1'b1; is_store = 1'($urandom); funct3 = 3'd2; addr = $urandom & 32'hFFFF_FFFC;
        end
      end
    end
    mem_ready = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done_wait: got no done in 300 cycles expected done at cycle %0d", exp_done);
      exp_q.delete();
      model_rdata = 32'd0;
      do_reset();
      return;
    end
    chk("done_cycle", c, exp_done);
    chk("req_cycles", reqs, exp_req);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors with literal pins on the model.
    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'd0, 0, 32'h80FF_1234, 1'b0);
    chk("lb_lit", rdata, 32'hFFFF_FF80);
    chk("lb_addr_lit", mem_addr, 32'h0000_1000);
    run_txn(1'b0, 3'd5, 32'h0000_2002, 32'd0, 1, 32'h9ABC_0000, 1'b0);
    chk("lhu_lit", rdata, 32'h0000_9ABC);
    run_txn(1'b0, 3'd1, 32'h0000_2002, 32'd0, 2, 32'h9ABC_0000, 1'b0);
    chk("lh_lit", rdata, 32'hFFFF_9ABC);
    run_txn(1'b1, 3'd0, 32'h0000_0001, 32'h1122_33AB, 0, 32'd0, 1'b0);
    chk("sb_wdata_lit", mem_wdata, 32'hABAB_ABAB);
    chk("sb_wmask_lit", {28'd0, mem_wmask}, 32'h2);
    chk("sb_rdata_kept", rdata, 32'hFFFF_9ABC);
    run_txn(1'b1, 3'd1, 32'h0000_0002, 32'h1122_33AB, 0, 32'd0, 1'b0);
    chk("sh_wdata_lit", mem_wdata, 32'h33AB_33AB);
    chk("sh_wmask_lit", {28'd0, mem_wmask}, 32'hC);
    run_txn(1'b0, 3'd2, 32'h0000_0006, 32'd0, 0, 32'h5555_5555, 1'b0);
    chk("lw_misal_lit", {30'd0, err}, 32'd1);
    run_txn(1'b0, 3'd3, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0);
    chk("ld_ill_lit", {30'd0, err}, 32'd2);
    run_txn(1'b1, 3'd4, 32'h0000_0000, 32'd0, 0, 32'd0, 1'b0);
    chk("st_ill_lit", {30'd0, err}, 32'd2);
    run_txn(1'b0, 3'd2, 32'h0000_0100, 32'd0, 10, 32'h1234_5678, 1'b0);
    chk("timeout_err_lit", {30'd0, err}, 32'd3);
    chk("timeout_rdata_kept", rdata, 32'hFFFF_9ABC);

    // Reset pulled in the middle of an ACCESS that never gets mem_ready.
    @(negedge clk);
    exp_we = 1'b0; exp_addr = 32'h0000_0040; exp_wdata = 32'd0; exp_wmask = 4'd0;
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0040; mem_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_req_high", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_mem_we", {31'd0, mem_we}, 32'd0);
    model_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 3'd4, 32'h0000_0301, 32'd0, 0, 32'hCAFE_F00D, 1'b1);
    run_txn(1'b0, 3'd2, 32'h0000_0304, 32'd0, 1, 32'hDEAD_BEEF, 1'b0);
    chk("after_rst_lw_lit", rdata, 32'hDEAD_BEEF);

    // Randomized transactions.
    for (int i = 0; i < 80; i++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 5)), $urandom, 1'($urandom));
    end

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_done: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
